// File: rtl/hilo_pkg.sv
// hilo_pkg: shared types and helpers for the HI/LO register unit.
//   hilo_op_e : 4-bit operation code presented on op_i
//   state_e   : sequencing state of hilo_unit
//   is_mult_class / is_acc_class / is_signed : operation classification helpers
package hilo_pkg;

  typedef enum logic [3:0] {
    NOP   = 4'd0,
    MTHI  = 4'd1,
    MTLO  = 4'd2,
    MULT  = 4'd3,
    MULTU = 4'd4,
    MADD  = 4'd5,
    MADDU = 4'd6,
    MSUB  = 4'd7,
    MSUBU = 4'd8
  } hilo_op_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_PROD = 2'd1,
    ACC       = 2'd2
  } state_e;

  // Plain multiplies: the product itself becomes {HI,LO}.
  function automatic logic is_mult_class(input logic [3:0] op);
    return (op == MULT) || (op == MULTU);
  endfunction

  // Multiply-accumulate/subtract: the product is folded into {HI,LO}.
  function automatic logic is_acc_class(input logic [3:0] op);
    return (op == MADD) || (op == MADDU) || (op == MSUB) || (op == MSUBU);
  endfunction

  // Only the multiplier cares about signedness.
  function automatic logic is_signed(input logic [3:0] op);
    return (op == MULT) || (op == MADD) || (op == MSUB);
  endfunction

endpackage

// File: rtl/hilo_unit_regs.sv
// hilo_regs: architectural HI and LO flops with independent write enables.
//   clk, rst             : clock, synchronous active-high reset (clears HI/LO)
//   hi_we, hi_wdata      : HI write enable / data, applied at the rising edge
//   lo_we, lo_wdata      : LO write enable / data, applied at the rising edge
//   hi_reg, lo_reg       : raw register contents (used by the accumulator)
//   hi_o, lo_o           : visible HI/LO
// Build option HILO_FWD_EN: when defined, hi_o/lo_o bypass the value being
// written at the coming edge; otherwise they show the registers only.
module hilo_regs
  import hilo_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [DATA_W-1:0] hi_wdata,
  input  logic [DATA_W-1:0] lo_wdata,
  output logic [DATA_W-1:0] hi_reg,
  output logic [DATA_W-1:0] lo_reg,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else begin
      if (hi_we) hi_reg <= hi_wdata;
      if (lo_we) lo_reg <= lo_wdata;
    end
  end

`ifdef HILO_FWD_EN
  // Back-to-back MFHI/MFLO sees the value retiring this cycle.
  assign hi_o = hi_we ? hi_wdata : hi_reg;
  assign lo_o = lo_we ? lo_wdata : lo_reg;
`else
  assign hi_o = hi_reg;
  assign lo_o = lo_reg;
`endif

endmodule

// File: rtl/hilo_unit.sv
// hilo_unit: HI/LO retire logic sitting behind the combinational multiplier.
//   clk, rst                  : clock, synchronous active-high reset
//   valid_i, op_i, wdata_i    : presented op (held stable while stall_o=1)
//   flush_i                   : drop any in-flight op, no HI/LO write
//   mult_start_o/mult_signed_o: multiplier request and signedness
//   prod_i, prod_ready_i      : multiplier product and its valid flag
//   hi_o, lo_o                : architectural HI/LO
//   stall_o                   : presented op does not retire this cycle
// Build option HILO_FWD_EN (see hilo_regs) forwards the retiring value.
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_i,
  input  logic [3:0]          op_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic                flush_i,
  output logic                mult_start_o,
  output logic                mult_signed_o,
  input  logic [2*DATA_W-1:0] prod_i,
  input  logic                prod_ready_i,
  output logic [DATA_W-1:0]   hi_o,
  output logic [DATA_W-1:0]   lo_o,
  output logic                stall_o
);

  state_e                state_reg, state_next;
  logic [3:0]            op_reg, op_next;
  logic [2*DATA_W-1:0]   prod_reg, prod_next;

  logic                  hi_we, lo_we;
  logic [DATA_W-1:0]     hi_wdata, lo_wdata;
  logic [DATA_W-1:0]     hi_reg, lo_reg;
  logic [2*DATA_W-1:0]   hilo_cur, acc_result;

  // Accumulation always works on the committed registers, never on the
  // forwarded outputs, so there is no combinational loop through hi_o/lo_o.
  assign hilo_cur   = {hi_reg, lo_reg};
  assign acc_result = ((op_reg == MSUB) || (op_reg == MSUBU)) ? (hilo_cur - prod_reg)
                                                              : (hilo_cur + prod_reg);

  always_comb begin
    state_next    = state_reg;
    op_next       = op_reg;
    prod_next     = prod_reg;
    stall_o       = 1'b0;
    mult_start_o  = 1'b0;
    mult_signed_o = 1'b0;
    hi_we         = 1'b0;
    lo_we         = 1'b0;
    hi_wdata      = '0;
    lo_wdata      = '0;

    if (rst || flush_i) begin
      // Everything quiet; the flops take care of returning to IDLE.
      state_next = IDLE;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (valid_i) begin
            if (op_i == MTHI) begin
              hi_we    = 1'b1;
              hi_wdata = wdata_i;
            end else if (op_i == MTLO) begin
              lo_we    = 1'b1;
              lo_wdata = wdata_i;
            end else if (is_mult_class(op_i) || is_acc_class(op_i)) begin
              mult_start_o  = 1'b1;
              mult_signed_o = is_signed(op_i);
              op_next       = op_i;
              if (!prod_ready_i) begin
                state_next = WAIT_PROD;
                stall_o    = 1'b1;
              end else if (is_acc_class(op_i)) begin
                prod_next  = prod_i;
                state_next = ACC;
                stall_o    = 1'b1;
              end else begin
                hi_we                = 1'b1;
                lo_we                = 1'b1;
                {hi_wdata, lo_wdata} = prod_i;
              end
            end
            // NOP and unknown codes fall through: nothing happens.
          end
        end

        WAIT_PROD: begin
          mult_start_o  = 1'b1;
          mult_signed_o = is_signed(op_reg);
          stall_o       = 1'b1;
          if (prod_ready_i) begin
            if (is_acc_class(op_reg)) begin
              prod_next  = prod_i;
              state_next = ACC;
            end else begin
              hi_we                = 1'b1;
              lo_we                = 1'b1;
              {hi_wdata, lo_wdata} = prod_i;
              stall_o              = 1'b0;
              state_next           = IDLE;
            end
          end
        end

        ACC: begin
          hi_we                = 1'b1;
          lo_we                = 1'b1;
          {hi_wdata, lo_wdata} = acc_result;
          state_next           = IDLE;
        end

        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      op_reg    <= NOP;
      prod_reg  <= '0;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      prod_reg  <= prod_next;
    end
  end

  hilo_regs #(
    .DATA_W(DATA_W)
  ) u_regs (
    .clk      (clk),
    .rst      (rst),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .hi_wdata (hi_wdata),
    .lo_wdata (lo_wdata),
    .hi_reg   (hi_reg),
    .lo_reg   (lo_reg),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: directed stimulus for hilo_unit with a per-cycle reference
// model and hand-computed expectations at the end of each scenario.
module tb_hilo_unit;
  import hilo_pkg::*;

`ifdef HILO_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        valid;
  logic [3:0]  op;
  logic [31:0] wdata;
  logic        flush;
  logic        mult_start;
  logic        mult_signed;
  logic [63:0] prod;
  logic        prod_ready;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        stall;

  int checks   = 0;
  int failures = 0;

  hilo_unit #(.DATA_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .valid_i       (valid),
    .op_i          (op),
    .wdata_i       (wdata),
    .flush_i       (flush),
    .mult_start_o  (mult_start),
    .mult_signed_o (mult_signed),
    .prod_i        (prod),
    .prod_ready_i  (prod_ready),
    .hi_o          (hi),
    .lo_o          (lo),
    .stall_o       (stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Architectural {HI,LO} plus the op that is still owed a result:
  // m_wait = waiting for the product, m_acc = product held, sum due next.
  logic [63:0] m_hilo = '0;
  logic [63:0] m_prod = '0;
  logic        m_wait = 1'b0;
  logic        m_acc  = 1'b0;
  logic        m_is_acc = 1'b0;
  logic        m_is_sub = 1'b0;
  logic        m_sgn    = 1'b0;

  logic        e_stall, e_start, e_signed, e_hwe, e_lwe;
  logic [63:0] e_new;
  logic [31:0] e_hi, e_lo;

  always @(negedge clk) begin
    e_stall = 1'b0; e_start = 1'b0; e_signed = 1'b0;
    e_hwe = 1'b0; e_lwe = 1'b0; e_new = m_hilo;
    if (!(rst || flush)) begin
      if (m_acc) begin
        e_new = m_is_sub ? (m_hilo - m_prod) : (m_hilo + m_prod);
        e_hwe = 1'b1; e_lwe = 1'b1;
      end else if (m_wait) begin
        e_start = 1'b1; e_signed = m_sgn;
        if (!prod_ready || m_is_acc) e_stall = 1'b1;
        else begin e_new = prod; e_hwe = 1'b1; e_lwe = 1'b1; end
      end else if (valid) begin
        if (op == MTHI) begin e_new[63:32] = wdata; e_hwe = 1'b1; end
        else if (op == MTLO) begin e_new[31:0] = wdata; e_lwe = 1'b1; end
        else if (op inside {MULT, MULTU, MADD, MADDU, MSUB, MSUBU}) begin
          e_start  = 1'b1;
          e_signed = op inside {MULT, MADD, MSUB};
          if (!prod_ready || op >= MADD) e_stall = 1'b1;
          else begin e_new = prod; e_hwe = 1'b1; e_lwe = 1'b1; end
        end
      end
    end
    e_hi = (FWD && e_hwe) ? e_new[63:32] : m_hilo[63:32];
    e_lo = (FWD && e_lwe) ? e_new[31:0]  : m_hilo[31:0];
    chk("stall", {63'd0, stall}, {63'd0, e_stall});
    chk("mult_start", {63'd0, mult_start}, {63'd0, e_start});
    chk("mult_signed", {63'd0, mult_signed}, {63'd0, e_signed});
    if (!rst) begin
      chk("hi", {32'd0, hi}, {32'd0, e_hi});
      chk("lo", {32'd0, lo}, {32'd0, e_lo});
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      m_hilo = '0; m_prod = '0; m_wait = 1'b0; m_acc = 1'b0;
    end else if (flush) begin
      m_wait = 1'b0; m_acc = 1'b0;
    end else begin
      if (e_hwe) m_hilo[63:32] = e_new[63:32];
      if (e_lwe) m_hilo[31:0]  = e_new[31:0];
      if (m_acc) m_acc = 1'b0;
      else if (m_wait) begin
        if (prod_ready) begin
          m_wait = 1'b0;
          if (m_is_acc) begin m_acc = 1'b1; m_prod = prod; end
        end
      end else if (valid && (op inside {MULT, MULTU, MADD, MADDU, MSUB, MSUBU})) begin
        m_is_acc = (op >= MADD);
        m_is_sub = (op >= MSUB);
        m_sgn    = op inside {MULT, MADD, MSUB};
        if (!prod_ready) m_wait = 1'b1;
        else if (op >= MADD) begin m_acc = 1'b1; m_prod = prod; end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic put(input logic v, input logic [3:0] o, input logic [31:0] wd,
                     input logic [63:0] p, input logic rdy, input logic fl);
    valid = v; op = o; wdata = wd; prod = p; prod_ready = rdy; flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    put(1'b0, NOP, 32'd0, 64'd0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    // 1. reset
    tick(); tick();
    rst = 1'b0;
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    chk("rst_stall", {63'd0, stall}, 64'd0);
    chk("rst_start", {63'd0, mult_start}, 64'd0);

    // 2. MTHI / MTLO
    put(1'b1, MTHI, 32'hDEADBEEF, 64'd0, 1'b0, 1'b0);
    @(negedge clk); chk("mthi_stall", {63'd0, stall}, 64'd0);
    tick();
    put(1'b1, MTLO, 32'h12345678, 64'd0, 1'b0, 1'b0);
    @(negedge clk); chk("mtlo_stall", {63'd0, stall}, 64'd0);
    tick(); idle();
    chk("mt_hi", {32'd0, hi}, 64'h00000000_DEADBEEF);
    chk("mt_lo", {32'd0, lo}, 64'h00000000_12345678);

    // 3. MULT with the product ready immediately
    put(1'b1, MULT, 32'd0, 64'hFFFFFFFF_FFFFFFFE, 1'b1, 1'b0);
    @(negedge clk);
    chk("mult_stall", {63'd0, stall}, 64'd0);
    chk("mult_signed", {63'd0, mult_signed}, 64'd1);
    tick(); idle();
    chk("mult_hi", {32'd0, hi}, 64'h00000000_FFFFFFFF);
    chk("mult_lo", {32'd0, lo}, 64'h00000000_FFFFFFFE);

    // 4. MADDU carry from LO into HI
    put(1'b1, MTHI, 32'h1, 64'd0, 1'b0, 1'b0); tick();
    put(1'b1, MTLO, 32'hFFFFFFFF, 64'd0, 1'b0, 1'b0); tick();
    put(1'b1, MADDU, 32'd0, 64'd1, 1'b1, 1'b0);
    @(negedge clk); chk("maddu_stall1", {63'd0, stall}, 64'd1);
    tick();
    @(negedge clk); chk("maddu_stall2", {63'd0, stall}, 64'd0);
    tick(); idle();
    chk("maddu_hi", {32'd0, hi}, 64'h00000000_00000002);
    chk("maddu_lo", {32'd0, lo}, 64'd0);

    // 5. MSUB wraps below zero
    put(1'b1, MTHI, 32'h0, 64'd0, 1'b0, 1'b0); tick();
    put(1'b1, MTLO, 32'h0, 64'd0, 1'b0, 1'b0); tick();
    put(1'b1, MSUB, 32'd0, 64'd1, 1'b1, 1'b0);
    tick(); tick(); idle();
    chk("msub_hi", {32'd0, hi}, 64'h00000000_FFFFFFFF);
    chk("msub_lo", {32'd0, lo}, 64'h00000000_FFFFFFFF);

    // 6. MULTU waiting, flushed, then MTLO retires at once
    put(1'b1, MULTU, 32'd0, 64'h12345678_9ABCDEF0, 1'b0, 1'b0);
    @(negedge clk); chk("flush_stall1", {63'd0, stall}, 64'd1);
    tick();
    flush = 1'b1;
    @(negedge clk);
    chk("flush_stall2", {63'd0, stall}, 64'd0);
    chk("flush_start", {63'd0, mult_start}, 64'd0);
    tick();
    put(1'b1, MTLO, 32'h5, 64'd0, 1'b0, 1'b0);
    @(negedge clk); chk("post_flush_stall", {63'd0, stall}, 64'd0);
    tick(); idle();
    chk("flush_hi", {32'd0, hi}, 64'h00000000_FFFFFFFF);
    chk("flush_lo", {32'd0, lo}, 64'h00000000_00000005);

    // 7. MULT through WAIT_PROD (product late by two cycles)
    put(1'b1, MULT, 32'd0, 64'd0, 1'b0, 1'b0); tick(); tick();
    put(1'b1, MULT, 32'd0, 64'h00000003_00000004, 1'b1, 1'b0); tick(); idle();
    chk("late_mult_hi", {32'd0, hi}, 64'h00000000_00000003);
    chk("late_mult_lo", {32'd0, lo}, 64'h00000000_00000004);

    // 8. MADD through WAIT_PROD then ACC
    put(1'b1, MADD, 32'd0, 64'd0, 1'b0, 1'b0); tick();
    put(1'b1, MADD, 32'd0, 64'd5, 1'b1, 1'b0); tick();
    put(1'b1, MADD, 32'd0, 64'd0, 1'b0, 1'b0); tick(); idle();
    chk("late_madd_hi", {32'd0, hi}, 64'h00000000_00000003);
    chk("late_madd_lo", {32'd0, lo}, 64'h00000000_00000009);

    // 9. unknown codes and NOP do nothing
    for (int i = 9; i < 16; i++) begin
      put(1'b1, 4'(i), 32'hAAAA5555, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0); tick();
    end
    put(1'b1, NOP, 32'h1, 64'd7, 1'b1, 1'b0); tick(); idle();
    chk("nop_hi", {32'd0, hi}, 64'h00000000_00000003);
    chk("nop_lo", {32'd0, lo}, 64'h00000000_00000009);

    // 10. reset during ACC loses the pending accumulate
    put(1'b1, MADDU, 32'd0, 64'd100, 1'b1, 1'b0); tick();
    rst = 1'b1; tick();
    rst = 1'b0; idle();
    chk("rst_acc_hi", {32'd0, hi}, 64'd0);
    chk("rst_acc_lo", {32'd0, lo}, 64'd0);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
